// File: rtl/fifo_wptr_full_pkg.sv
// Package for the write-side pointer controller: default sizing and helpers
// shared with the interface and the top.
`include "fifo_defs.vh"

package fifo_wptr_full_pkg;

  localparam int DEFAULT_ADDR_WIDTH = `FIFO_DEFAULT_ADDR_WIDTH;

  function automatic int depth_of(input int addr_width);
    return `FIFO_DEPTH(addr_width);
  endfunction

  function automatic int ptr_width_of(input int addr_width);
    return `FIFO_PTR_WIDTH(addr_width);
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-domain bundle between the producer and the write-pointer controller.
// master: producer side (drives wr_en, rptr_sync); slave: the controller.
module fifo_wptr_full_if_dummy_guard; endmodule

interface fifo_wptr_full_if
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  logic                  wr_en;
  logic [PTR_WIDTH-1:0]  rptr_sync;
  logic [PTR_WIDTH-1:0]  wptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wr_accept;
  logic                  full;
  logic [PTR_WIDTH-1:0]  level;
  logic                  overflow;
  logic                  almost_full;

  modport master (
    output wr_en, rptr_sync,
    input  wptr, waddr, wr_accept, full, level, overflow, almost_full
  );

  modport slave (
    input  wr_en, rptr_sync,
    output wptr, waddr, wr_accept, full, level, overflow, almost_full
  );

endinterface

// File: rtl/fifo_defs.vh
// Shared FIFO sizing helpers for the write-side and read-side pointer blocks.
// Pulled in by fifo_wptr_full and, later, fifo_rptr_empty.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DEFAULT_ADDR_WIDTH 4
`define FIFO_DEPTH(aw) (1 << (aw))
`define FIFO_PTR_WIDTH(aw) ((aw) + 1)
`define FIFO_PTR_RST '0

`endif

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag controller of the async FIFO (write clock
// domain). Owns the registered binary write pointer that feeds the RAM write
// address and the read-domain synchronizer; derives full, fill level and
// overflow from the read pointer already synchronized into this domain.
// Optional almost_full comparator: define FIFO_WPTR_ALMOST_FULL_EN.
`include "fifo_defs.vh"

module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int PTR_WIDTH    = `FIFO_PTR_WIDTH(ADDR_WIDTH),
  parameter int AFULL_THRESH = `FIFO_DEPTH(ADDR_WIDTH) - 2
) (
  input logic             clk,
  input logic             rst,
  fifo_wptr_full_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [PTR_WIDTH-1:0] DEPTH_LVL = PTR_WIDTH'(DEPTH);

  // The wrap bit is what lets level reach DEPTH, so the width is not free.
  if (PTR_WIDTH != ptr_width_of(ADDR_WIDTH)) begin : g_bad_ptr_width
    $error("fifo_wptr_full: PTR_WIDTH must be ADDR_WIDTH+1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fifo_wptr_full: AFULL_THRESH out of range 1..DEPTH");
  end

  logic [PTR_WIDTH-1:0] wptr_q;
  logic [PTR_WIDTH-1:0] wptr_nxt;
  logic [PTR_WIDTH-1:0] level_q;
  logic [PTR_WIDTH-1:0] level_nxt;
  logic                 full_q;
  logic                 full_nxt;
  logic                 overflow_q;
  logic                 accept;

  // Reset masks the RAM write enable so a write concurrent with reset never
  // lands in the RAM; outside reset this is exactly wr_en & ~full.
  assign accept    = bus.wr_en & ~full_q & ~rst;
  assign wptr_nxt  = wptr_q + PTR_WIDTH'(accept);
  // Modular difference keeps the level correct across the pointer wrap.
  assign level_nxt = wptr_nxt - bus.rptr_sync;
  assign full_nxt  = (level_nxt == DEPTH_LVL);

  // Pointer, level, full and overflow registers; reset wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= `FIFO_PTR_RST;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_nxt;
      level_q    <= level_nxt;
      full_q     <= full_nxt;
      overflow_q <= bus.wr_en & full_q;
    end
  end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam logic [PTR_WIDTH-1:0] AFULL_LVL = PTR_WIDTH'(AFULL_THRESH);
  logic afull_q;

  // Almost-full tracks the next level with the same timing as full.
  always_ff @(posedge clk) begin
    if (rst) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (level_nxt >= AFULL_LVL);
    end
  end

  assign bus.almost_full = afull_q;
`else
  assign bus.almost_full = 1'b0;
`endif

  // wptr goes straight from the register to the downstream Gray encoder.
  assign bus.wptr      = wptr_q;
  assign bus.waddr     = wptr_q[ADDR_WIDTH-1:0];
  assign bus.wr_accept = accept;
  assign bus.full      = full_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;

`ifndef SYNTHESIS
  logic [PTR_WIDTH-1:0] occ_now;
  assign occ_now = wptr_q - bus.rptr_sync;

  // A synchronized read pointer more than DEPTH behind (or ahead of) wptr
  // means the read side broke protocol.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_now <= DEPTH_LVL);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed plan steps plus a randomized phase,
// checked against an occupancy model built from unbounded write/read counts.
module tb_fifo_wptr_full;

  localparam int AW    = 4;
  localparam int PW    = 5;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int PMOD  = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wptr_full #(
    .ADDR_WIDTH  (AW),
    .PTR_WIDTH   (PW),
    .AFULL_THRESH(AFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: total accepted writes since reset, and the last read count driven.
  int wcnt    = 0;
  int rcnt    = 0;
  int level_m = 0;
  bit full_m  = 1'b0;
  bit ovf_m   = 1'b0;
  bit af_m    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit w, input int rp);
    bit acc;
    rst           = r;
    bus.wr_en     = w;
    bus.rptr_sync = PW'(rp % PMOD);
    #1;
    acc = w && !full_m && !r;
    chk("wr_accept", bus.wr_accept, acc);
    @(posedge clk);
    if (r) begin
      wcnt = 0; level_m = 0; full_m = 0; ovf_m = 0; af_m = 0;
    end else begin
      ovf_m   = w && full_m;
      wcnt    = wcnt + int'(acc);
      level_m = ((wcnt - rp) % PMOD + PMOD) % PMOD;
      full_m  = (level_m == DEPTH);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
      af_m    = (level_m >= AFT);
`else
      af_m    = 1'b0;
`endif
    end
    #1;
    chk("wptr",        bus.wptr,        wcnt % PMOD);
    chk("waddr",       bus.waddr,       wcnt % DEPTH);
    chk("level",       bus.level,       level_m);
    chk("full",        bus.full,        full_m);
    chk("overflow",    bus.overflow,    ovf_m);
    chk("almost_full", bus.almost_full, af_m);
  endtask

  initial begin
    int wrap_ptr [4];
    int wrap_addr[4];
    int budget;
    bit w;
    wrap_ptr  = '{31, 0, 1, 2};
    wrap_addr = '{15, 0, 1, 2};

    // Reset held two cycles with a write request pending.
    cycle(1'b1, 1'b1, 0);
    cycle(1'b1, 1'b1, 0);
    chk("rst_wptr",  bus.wptr,  0);
    chk("rst_level", bus.level, 0);
    chk("rst_full",  bus.full,  0);
    chk("rst_ovf",   bus.overflow, 0);

    // Fill from empty.
    rcnt = 0;
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, rcnt);
    chk("fill_wptr",  bus.wptr,  16);
    chk("fill_waddr", bus.waddr, 0);
    chk("fill_level", bus.level, 16);
    chk("fill_full",  bus.full,  1);

    // Refused writes while full.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, rcnt);
      chk("ovf_pulse", bus.overflow, 1);
      chk("ovf_wptr",  bus.wptr, 16);
    end

    // wr_en drops while the reader frees four entries.
    rcnt = 4;
    cycle(1'b0, 1'b0, rcnt);
    chk("drain_ovf",   bus.overflow, 0);
    chk("drain_full",  bus.full, 0);
    chk("drain_level", bus.level, 12);

    // Walk both pointers up to 30 with the reader keeping pace.
    budget = 0;
    while (wcnt < 30 && budget < 64) begin
      rcnt = wcnt;
      cycle(1'b0, 1'b1, rcnt);
      budget++;
    end
    chk("walk_budget", wcnt, 30);
    rcnt = 30;
    cycle(1'b0, 1'b0, rcnt);
    chk("walk_level", bus.level, 0);

    // Writes across the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, rcnt);
      chk("wrap_wptr",  bus.wptr,  wrap_ptr[i]);
      chk("wrap_waddr", bus.waddr, wrap_addr[i]);
      chk("wrap_level", bus.level, i + 1);
      chk("wrap_full",  bus.full,  0);
    end

    // Randomized writes and reader progress (never overtaking the writer).
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) rcnt = rcnt + $urandom_range(0, wcnt - rcnt);
      cycle(1'b0, w, rcnt);
    end

    // Mid-burst reset.
    rcnt = 0;
    cycle(1'b1, 1'b0, rcnt);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, rcnt);
    chk("mid_wptr_pre", bus.wptr, 9);
    cycle(1'b1, 1'b1, rcnt);
    chk("mid_wptr",  bus.wptr,  0);
    chk("mid_level", bus.level, 0);
    chk("mid_full",  bus.full,  0);
    chk("resume_waddr", bus.waddr, 0);
    cycle(1'b0, 1'b1, rcnt);
    chk("resume_wptr",  bus.wptr,  1);
    chk("resume_level", bus.level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
